top_bar_vga: RTL and testbench

// VGA 640x480@60 timing generator plus colour-target tracker for the camera robot.
// - Drives camera read coordinates (cam_x, cam_y) and accepts the matching 8-bit RGB pixel

---
 rtl/top_bar_vga_if.sv | 27 ++
 rtl/top_bar_vga.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_top_bar_vga.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/top_bar_vga_if.sv
// -----------------------------------------------------------------------------
// top_bar_vga_if
// Camera read bus between the VGA timing/tracker block and the camera frame
// memory. The tracker presents a read coordinate and the memory answers
// combinationally with the 8-bit RGB pixel stored at that coordinate.
//
// Signals
//   cam_x  [9:0]  horizontal read coordinate (raw VGA h counter, 0..799)
//   cam_y  [8:0]  vertical read coordinate (low 9 bits of the VGA v counter)
//   r_top  [7:0]  red   component of the pixel at (cam_x, cam_y)
//   g_top  [7:0]  green component of the pixel at (cam_x, cam_y)
//   b_top  [7:0]  blue  component of the pixel at (cam_x, cam_y)
//
// Modports
//   master : tracker side, drives the coordinate and receives the pixel
//   slave  : camera memory side
// -----------------------------------------------------------------------------
interface top_bar_vga_if;
  logic [9:0] cam_x;
  logic [8:0] cam_y;
  logic [7:0] r_top;
  logic [7:0] g_top;
  logic [7:0] b_top;

  modport master (output cam_x, cam_y, input r_top, g_top, b_top);
  modport slave  (input cam_x, cam_y, output r_top, g_top, b_top);
endinterface

// File: rtl/top_bar_vga.sv
// -----------------------------------------------------------------------------
// top_bar_vga
// VGA 640x480@60 timing generator with a colour-target tracker.
//   * Scans the camera memory through the cam bus and produces a registered
//     detection mask (255/0) and an annotated copy of the image.
//   * Accumulates the coordinates of target pixels inside the camera area
//     (cam_x < CAM_W, v < V_VIS) and, once per frame, divides the sums by the
//     pixel count with a sequential restoring divider to get the barycentre.
//
// Ports
//   CLK_top            in   pixel clock (25 MHz)
//   reset_top          in   synchronous reset, active low
//   SW1_top            in   1 = tracking/annotation on, 0 = pass-through
//   cam                bus  top_bar_vga_if.master (cam_x/cam_y out, RGB in)
//   rout/gout/bout_top out  annotated pixel stream
//   r/g/b_out_proc     out  detection mask, 255 or 0 on all three channels
//   X/Y_barycentre_top out  barycentre of the previous frame (camera coords)
//   HSYNC_top          out  horizontal sync, active low
//   VSYNC_top          out  vertical sync, active low
//   IMG_top            out  1 inside the visible area
// All pixel outputs, syncs and IMG are registered one clock after the
// coordinate that produced them.
//
// Build option
//   CROSSHAIR_EN : when defined, the marker is a full-length crosshair through
//                  the barycentre; otherwise a 5x5 square centred on it.
//   Both are limited to the camera area and drawn in (0, MARK_C, 0).
//
// The timing parameters default to the 640x480@60 mode; they exist so the
// same logic can be exercised with a reduced raster.
// -----------------------------------------------------------------------------
module top_bar_vga #(
  parameter int         H_VIS  = 640,
  parameter int         H_FP   = 16,
  parameter int         H_SYNC = 96,
  parameter int         H_BP   = 48,
  parameter int         V_VIS  = 480,
  parameter int         V_FP   = 10,
  parameter int         V_SYNC = 2,
  parameter int         V_BP   = 33,
  parameter int         CAM_W  = 512,
  parameter logic [7:0] R_MIN  = 8'd128,
  parameter logic [7:0] GB_MAX = 8'd64,
  parameter logic [7:0] MARK_C = 8'd255
) (
  input  logic                 CLK_top,
  input  logic                 reset_top,
  input  logic                 SW1_top,
  top_bar_vga_if.master        cam,
  output logic [7:0]           rout_top,
  output logic [7:0]           gout_top,
  output logic [7:0]           bout_top,
  output logic [7:0]           r_out_proc,
  output logic [7:0]           g_out_proc,
  output logic [7:0]           b_out_proc,
  output logic [8:0]           X_barycentre_top,
  output logic [8:0]           Y_barycentre_top,
  output logic                 HSYNC_top,
  output logic                 VSYNC_top,
  output logic                 IMG_top
);

  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] H_LAST_C = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_BEG_C = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END_C = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] V_LAST_C = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_BEG_C = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END_C = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] CAM_W_C  = 10'(CAM_W);
  localparam logic [4:0] LAST_STEP = 5'd26;  // 27 quotient bits per division

  typedef enum logic [1:0] {DIV_IDLE, DIV_X, DIV_Y} div_state_t;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST_C) begin
      h_d = '0;
      v_d = (v_q == V_LAST_C) ? '0 : v_q + 10'd1;
    end
  end

  assign cam.cam_x = h_q;
  assign cam.cam_y = v_q[8:0];

  // ---------------------------------------------------------------------------
  // Pixel classification for the coordinate currently on the bus
  // ---------------------------------------------------------------------------
  logic       vis, valid, target, hit, in_mark, frame_start;
  logic [8:0] x_bary_q, x_bary_d, y_bary_q, y_bary_d;

  assign vis         = (h_q < H_VIS_C) && (v_q < V_VIS_C);
  assign valid       = (h_q < CAM_W_C) && (v_q < V_VIS_C);
  assign target      = (cam.r_top > R_MIN) && (cam.g_top < GB_MAX) && (cam.b_top < GB_MAX);
  assign hit         = target && valid && SW1_top;
  assign frame_start = (h_q == 10'd0) && (v_q == 10'd0);

`ifdef CROSSHAIR_EN
  assign in_mark = valid && ((h_q == {1'b0, x_bary_q}) || (v_q == {1'b0, y_bary_q}));
`else
  // 11-bit arithmetic so that "h + 2 >= X" cannot wrap near the counter top.
  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic        near_x, near_y;
  assign h_ext   = {1'b0, h_q};
  assign v_ext   = {1'b0, v_q};
  assign x_ext   = {2'b0, x_bary_q};
  assign y_ext   = {2'b0, y_bary_q};
  assign near_x  = (h_ext + 11'd2 >= x_ext) && (h_ext <= x_ext + 11'd2);
  assign near_y  = (v_ext + 11'd2 >= y_ext) && (v_ext <= y_ext + 11'd2);
  assign in_mark = valid && near_x && near_y;
`endif

  // ---------------------------------------------------------------------------
  // Registered video outputs
  // ---------------------------------------------------------------------------
  logic       hsync_q, hsync_d, vsync_q, vsync_d, img_q, img_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] rout_q, rout_d, gout_q, gout_d, bout_q, bout_d;

  always_comb begin
    hsync_d = !((h_q >= HS_BEG_C) && (h_q < HS_END_C));
    vsync_d = !((v_q >= VS_BEG_C) && (v_q < VS_END_C));
    img_d   = vis;
    mask_d  = '0;
    rout_d  = '0;
    gout_d  = '0;
    bout_d  = '0;
    if (vis) begin
      rout_d = cam.r_top;
      gout_d = cam.g_top;
      bout_d = cam.b_top;
      if (SW1_top) begin
        if (target) mask_d = 8'hFF;
        if (in_mark) begin
          rout_d = 8'd0;
          gout_d = MARK_C;
          bout_d = 8'd0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators. The clear at (0,0) and the contribution of pixel (0,0) are
  // merged so that pixel is not lost.
  // ---------------------------------------------------------------------------
  logic [26:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [17:0] cnt_q, cnt_d;

  always_comb begin
    sum_x_d = (frame_start ? 27'd0 : sum_x_q) + (hit ? {17'd0, h_q} : 27'd0);
    sum_y_d = (frame_start ? 27'd0 : sum_y_q) + (hit ? {17'd0, v_q} : 27'd0);
    cnt_d   = (frame_start ? 18'd0 : cnt_q) + (hit ? 18'd1 : 18'd0);
  end

  // ---------------------------------------------------------------------------
  // Restoring divider: sum_x/cnt, then sum_y/cnt, 27 steps each. Operands are
  // captured at (0, V_VIS), long before the accumulators clear at (0,0).
  // dvd_q shifts the dividend out at the top and the quotient in at the bottom.
  // ---------------------------------------------------------------------------
  div_state_t  state_q, state_d;
  logic [26:0] dvd_q, dvd_d, sy_op_q, sy_op_d, quo_next;
  logic [17:0] rem_q, rem_d, dvs_q, dvs_d, rem_sub;
  logic [18:0] rem_shift;
  logic [4:0]  step_q, step_d;
  logic [8:0]  qx_q, qx_d;
  logic        rem_ge, div_start;

  assign div_start = (h_q == 10'd0) && (v_q == V_VIS_C) && (cnt_q != 18'd0);
  assign rem_shift = {rem_q, dvd_q[26]};
  assign rem_ge    = rem_shift >= {1'b0, dvs_q};
  // Only used when rem_ge, where the true difference is below dvs_q.
  assign rem_sub   = rem_shift[17:0] - dvs_q;
  assign quo_next  = {dvd_q[25:0], rem_ge};

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    sy_op_d  = sy_op_q;
    step_d   = step_q;
    qx_d     = qx_q;
    x_bary_d = x_bary_q;
    y_bary_d = y_bary_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_start) begin
          state_d = DIV_X;
          dvd_d   = sum_x_q;
          sy_op_d = sum_y_q;
          dvs_d   = cnt_q;
          rem_d   = '0;
          step_d  = '0;
        end
      end
      DIV_X: begin
        dvd_d  = quo_next;
        rem_d  = rem_ge ? rem_sub : rem_shift[17:0];
        step_d = step_q + 5'd1;
        if (step_q == LAST_STEP) begin
          qx_d    = quo_next[8:0];
          dvd_d   = sy_op_q;
          rem_d   = '0;
          step_d  = '0;
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        dvd_d  = quo_next;
        rem_d  = rem_ge ? rem_sub : rem_shift[17:0];
        step_d = step_q + 5'd1;
        if (step_q == LAST_STEP) begin
          // Both coordinates update on the same edge.
          x_bary_d = qx_q;
          y_bary_d = quo_next[8:0];
          state_d  = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_top) begin
    if (!reset_top) begin
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      img_q    <= 1'b0;
      mask_q   <= '0;
      rout_q   <= '0;
      gout_q   <= '0;
      bout_q   <= '0;
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      cnt_q    <= '0;
      state_q  <= DIV_IDLE;
      dvd_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      sy_op_q  <= '0;
      step_q   <= '0;
      qx_q     <= '0;
      x_bary_q <= '0;
      y_bary_q <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      img_q    <= img_d;
      mask_q   <= mask_d;
      rout_q   <= rout_d;
      gout_q   <= gout_d;
      bout_q   <= bout_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      sy_op_q  <= sy_op_d;
      step_q   <= step_d;
      qx_q     <= qx_d;
      x_bary_q <= x_bary_d;
      y_bary_q <= y_bary_d;
    end
  end

  assign HSYNC_top        = hsync_q;
  assign VSYNC_top        = vsync_q;
  assign IMG_top          = img_q;
  assign r_out_proc       = mask_q;
  assign g_out_proc       = mask_q;
  assign b_out_proc       = mask_q;
  assign rout_top         = rout_q;
  assign gout_top         = gout_q;
  assign bout_top         = bout_q;
  assign X_barycentre_top = x_bary_q;
  assign Y_barycentre_top = y_bary_q;

endmodule

// File: tb/tb_top_bar_vga.sv
// -----------------------------------------------------------------------------
// tb_top_bar_vga
// Drives a reduced raster instance (80x50 total, 64x40 visible, 48-column
// camera area) through a sequence of frames and compares every output on
// every cycle with a reference model computed from raster position, a frame
// image and per-frame sums. A second instance with the default 640x480
// timing is checked over its first two lines.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_top_bar_vga;
  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 40, V_FP = 3, V_SYNC = 2, V_BP = 5;
  localparam int CAM_W = 48;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;
  localparam int N_FRAMES = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sw;
  top_bar_vga_if cam_bus ();
  top_bar_vga_if cam_full ();

  logic [7:0] rout, gout, bout, rmask, gmask, bmask;
  logic [8:0] xb, yb;
  logic       hs, vs, img;
  logic [7:0] f_rout, f_gout, f_bout, f_rmask, f_gmask, f_bmask;
  logic [8:0] f_xb, f_yb;
  logic       f_hs, f_vs, f_img;

  top_bar_vga #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CAM_W(CAM_W)
  ) dut (
    .CLK_top(clk), .reset_top(rst_n), .SW1_top(sw), .cam(cam_bus),
    .rout_top(rout), .gout_top(gout), .bout_top(bout),
    .r_out_proc(rmask), .g_out_proc(gmask), .b_out_proc(bmask),
    .X_barycentre_top(xb), .Y_barycentre_top(yb),
    .HSYNC_top(hs), .VSYNC_top(vs), .IMG_top(img)
  );

  top_bar_vga dut_full (
    .CLK_top(clk), .reset_top(rst_n), .SW1_top(sw), .cam(cam_full),
    .rout_top(f_rout), .gout_top(f_gout), .bout_top(f_bout),
    .r_out_proc(f_rmask), .g_out_proc(f_gmask), .b_out_proc(f_bmask),
    .X_barycentre_top(f_xb), .Y_barycentre_top(f_yb),
    .HSYNC_top(f_hs), .VSYNC_top(f_vs), .IMG_top(f_img)
  );

  // Camera memory of the current frame; the full-size instance sees black.
  logic [7:0] mem_r [V_VIS][H_VIS];
  logic [7:0] mem_g [V_VIS][H_VIS];
  logic [7:0] mem_b [V_VIS][H_VIS];

  always_comb begin
    cam_bus.r_top = 8'd0;
    cam_bus.g_top = 8'd0;
    cam_bus.b_top = 8'd0;
    if (int'(cam_bus.cam_y) < V_VIS && int'(cam_bus.cam_x) < H_VIS) begin
      cam_bus.r_top = mem_r[int'(cam_bus.cam_y)][int'(cam_bus.cam_x)];
      cam_bus.g_top = mem_g[int'(cam_bus.cam_y)][int'(cam_bus.cam_x)];
      cam_bus.b_top = mem_b[int'(cam_bus.cam_y)][int'(cam_bus.cam_x)];
    end
  end
  assign cam_full.r_top = 8'd0;
  assign cam_full.g_top = 8'd0;
  assign cam_full.b_top = 8'd0;

  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int p, acc_x, acc_y, acc_n, mx, my, win_end;
  int exp_cx, exp_cy;
  logic exp_hs, exp_vs, exp_img;
  logic [7:0] exp_mask, exp_r, exp_g, exp_b;
  int pf, exp_cxf;
  logic exp_hsf, exp_vsf, exp_imgf;
  logic [7:0] exp_gf;

  function automatic logic is_target(input logic [7:0] r, g, b);
    return (r > 8'd128) && (g < 8'd64) && (b < 8'd64);
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic logic on_marker(input int h, v, cx, cy, cam_w, v_vis);
    if (!(h < cam_w && v < v_vis)) return 1'b0;
`ifdef CROSSHAIR_EN
    return (h == cx) || (v == cy);
`else
    return (iabs(h - cx) <= 2) && (iabs(v - cy) <= 2);
`endif
  endfunction

  // Computes what the outputs hold after the coming clock edge.
  task automatic model_step();
    int h, v, hf, vf;
    logic vis_m, tgt;
    logic [7:0] pr, pg, pb;
    if (!rst_n) begin
      p = 0; acc_x = 0; acc_y = 0; acc_n = 0; mx = 0; my = 0; win_end = 0;
      exp_hs = 1'b1; exp_vs = 1'b1; exp_img = 1'b0; exp_mask = 8'd0;
      exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
      pf = 0; exp_hsf = 1'b1; exp_vsf = 1'b1; exp_imgf = 1'b0; exp_gf = 8'd0;
    end else begin
      h = p % HT; v = p / HT;
      vis_m = (h < H_VIS) && (v < V_VIS);
      pr = vis_m ? mem_r[v][h] : 8'd0;
      pg = vis_m ? mem_g[v][h] : 8'd0;
      pb = vis_m ? mem_b[v][h] : 8'd0;
      tgt = is_target(pr, pg, pb);
      exp_hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
      exp_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
      exp_img = vis_m;
      exp_mask = (vis_m && sw && tgt) ? 8'd255 : 8'd0;
      if (!vis_m) begin
        exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
      end else if (sw && on_marker(h, v, mx, my, CAM_W, V_VIS)) begin
        exp_r = 8'd0; exp_g = 8'd255; exp_b = 8'd0;
      end else begin
        exp_r = pr; exp_g = pg; exp_b = pb;
      end
      if (p == 0) begin acc_x = 0; acc_y = 0; acc_n = 0; end
      if (h < CAM_W && v < V_VIS && sw && tgt) begin
        acc_x += h; acc_y += v; acc_n++;
      end
      if (h == 0 && v == V_VIS && acc_n > 0) begin
        mx = acc_x / acc_n; my = acc_y / acc_n;
        win_end = cyc + 64;
      end
      p = (p + 1) % FT;
      // Default-timing instance: black input, switch on, barycentre (0,0).
      hf = pf % 800; vf = pf / 800;
      exp_hsf  = !(hf >= 656 && hf < 752);
      exp_vsf  = !(vf >= 490 && vf < 492);
      exp_imgf = (hf < 640) && (vf < 480);
      exp_gf   = (sw && on_marker(hf, vf, 0, 0, 512, 480)) ? 8'd255 : 8'd0;
      pf = (pf + 1) % 420000;
    end
    exp_cx = p % HT; exp_cy = p / HT;
    exp_cxf = pf % 800;
  endtask

  // ---------------------------------------------------------------------------
  // Frame images
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] pick_r();
    case ($urandom_range(0, 3))
      0: return 8'd128;
      1: return 8'd129;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  function automatic logic [7:0] pick_gb();
    case ($urandom_range(0, 3))
      0: return 8'd63;
      1: return 8'd64;
      default: return 8'($urandom_range(0, 90));
    endcase
  endfunction

  task automatic fill_black();
    for (int y = 0; y < V_VIS; y++)
      for (int x = 0; x < H_VIS; x++) begin
        mem_r[y][x] = 8'd0; mem_g[y][x] = 8'd0; mem_b[y][x] = 8'd0;
      end
  endtask

  task automatic fill_noise();
    for (int y = 0; y < V_VIS; y++)
      for (int x = 0; x < H_VIS; x++) begin
        mem_r[y][x] = pick_r(); mem_g[y][x] = pick_gb(); mem_b[y][x] = pick_gb();
      end
  endtask

  task automatic put_red(input int x, input int y);
    mem_r[y][x] = 8'd255; mem_g[y][x] = 8'd0; mem_b[y][x] = 8'd0;
  endtask

  int fnum, sx, sy, qx, qy, hold_x, hold_y, tog_p, pulse_cnt, end_cyc;
  logic tog_done, pulse_done;

  // Frame sequence: 0 black, 1 single red pixel, 2 red 11x11 square,
  // 3 noise, 4 noise with switch off, 5 noise with a mid-frame switch toggle,
  // 6 noise with a reset pulse, 7 red only outside the camera area, 8 noise.
  task automatic prep_frame(input int f);
    sw = (f != 4);
    case (f)
      1: begin
        fill_black();
        sx = $urandom_range(0, CAM_W - 1); sy = $urandom_range(0, V_VIS - 1);
        put_red(sx, sy);
      end
      2: begin
        fill_black();
        qx = $urandom_range(0, CAM_W - 11); qy = $urandom_range(0, V_VIS - 11);
        for (int y = 0; y < 11; y++)
          for (int x = 0; x < 11; x++) put_red(qx + x, qy + y);
      end
      7: begin
        fill_black();
        for (int i = 0; i < 6; i++)
          put_red($urandom_range(CAM_W, H_VIS - 1), $urandom_range(0, V_VIS - 1));
      end
      default: fill_noise();
    endcase
    tog_p = $urandom_range(5 * HT, 30 * HT);
  endtask

  // Explicit per-scenario barycentre checks, taken one line after the
  // division started.
  task automatic frame_checks(input int f);
    case (f)
      0: check_eq("black_xy", {xb, yb}, 18'd0);
      1: check_eq("single_xy", {xb, yb}, {9'(sx), 9'(sy)});
      2: check_eq("square_xy", {xb, yb}, {9'(qx + 5), 9'(qy + 5)});
      3: begin hold_x = mx; hold_y = my; end
      4: check_eq("sw_off_hold_xy", {xb, yb}, {9'(hold_x), 9'(hold_y)});
      6: begin hold_x = mx; hold_y = my; end
      7: check_eq("zero_cnt_hold_xy", {xb, yb}, {9'(hold_x), 9'(hold_y)});
      default: ;
    endcase
  endtask

  initial begin
    rst_n = 1'b0; sw = 1'b1; fnum = 0; end_cyc = 60000;
    tog_done = 1'b0; pulse_done = 1'b0; pulse_cnt = 0;
    fill_black();
    model_step();
    while (cyc < end_cyc) begin
      @(negedge clk);
      cyc++;
      check_eq("cam_xy", {cam_bus.cam_x, cam_bus.cam_y}, {10'(exp_cx), 9'(exp_cy)});
      check_eq("sync_img", {hs, vs, img}, {exp_hs, exp_vs, exp_img});
      check_eq("mask", {rmask, gmask, bmask}, {exp_mask, exp_mask, exp_mask});
      check_eq("annot", {rout, gout, bout}, {exp_r, exp_g, exp_b});
      if (cyc >= win_end)
        check_eq("bary_xy", {xb, yb}, {9'(mx), 9'(my)});
      if (cyc < 1800) begin
        check_eq("full_sync_img", {f_hs, f_vs, f_img}, {exp_hsf, exp_vsf, exp_imgf});
        check_eq("full_cam_x", {22'd0, cam_full.cam_x}, 32'(exp_cxf));
        check_eq("full_pix", {f_rout, f_gout, f_bout, f_rmask, f_gmask, f_bmask},
                 {8'd0, exp_gf, 8'd0, 24'd0});
        check_eq("full_xy", {f_xb, f_yb}, 18'd0);
      end

      if (rst_n && p == (V_VIS + 1) * HT && fnum < N_FRAMES) begin
        frame_checks(fnum);
        fnum++;
        if (fnum < N_FRAMES) prep_frame(fnum);
        else end_cyc = cyc + 100;
      end

      if (fnum == 5 && !tog_done && p == tog_p) begin
        sw = ~sw; tog_done = 1'b1;
      end
      if (fnum == 6 && !pulse_done && p == 20 * HT + 7) begin
        pulse_cnt = 2; pulse_done = 1'b1;
      end
      if (cyc < 3) rst_n = 1'b0;
      else if (pulse_cnt > 0) begin rst_n = 1'b0; pulse_cnt--; end
      else rst_n = 1'b1;
      model_step();
    end
    check_eq("frames_done", 64'(fnum), 64'(N_FRAMES));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
